// File: rtl/bf16_pkg.sv
// bf16_pkg: bf16 field layout, widths and the subnormal flush helper
package bf16_pkg;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  typedef struct packed {
    logic                  sign;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;
  function automatic bf16_t bf16_ftz(input bf16_t x);
    bf16_t r;
    r = x;
    if (x.exp == '0) r.man = '0;
    return r;
  endfunction
endpackage

// File: rtl/bf16_rsp_fifo.sv
// bf16_rsp_fifo: per-requester in-order result buffer; head reads as 0 when empty
module bf16_rsp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic        valid
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          pop;
  assign valid   = cnt != '0;
  assign pop     = rd_en && valid;
  assign rd_data = valid ? mem[rp] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + {AW'(0), wr_en} - {AW'(0), pop};
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= wr_data;
endmodule

// File: rtl/bf16_mac_arb.sv
// bf16_mac_arb: round-robin sharing of one external bf16 MAC between two credited requesters.
// Define BF16_FTZ_EN to flush subnormal MAC results to signed zero before buffering.
module bf16_mac_arb
  import bf16_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_c,
  output logic        mac_valid,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic [15:0] mac_c,
  input  logic        mac_res_valid,
  input  logic [15:0] mac_res,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        err
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0]  credit [2];
  logic [1:0]     elig, gnt, rsp_hs, wr_en;
  logic           ptr, win, mac_id;
  logic [LAT-1:0] tag_v, tag_id;
  logic [15:0]    wdata;
  // credit covers buffered plus in-flight results, so an eligible grant can never overflow its FIFO
  always_comb begin
    for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (credit[i] < CW'(DEPTH));
    win = (&elig) ? ptr : elig[1];
    gnt = (rst || !(|elig)) ? 2'b00 : (win ? 2'b10 : 2'b01);
  end
  assign req_ready = gnt;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign busy      = (credit[0] != '0) || (credit[1] != '0);
  assign wr_en     = {tag_v[LAT-1] && tag_id[LAT-1], tag_v[LAT-1] && !tag_id[LAT-1]};
`ifdef BF16_FTZ_EN
  assign wdata = bf16_ftz(bf16_t'(mac_res));
`else
  assign wdata = mac_res;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr       <= 1'b0;
      mac_valid <= 1'b0;
      mac_id    <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_c     <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
      err       <= 1'b0;
      credit    <= '{default: '0};
    end else begin
      mac_valid <= |gnt;
      if (|gnt) begin
        ptr    <= ~win;
        mac_id <= win;
        mac_a  <= win ? req_a[31:16] : req_a[15:0];
        mac_b  <= win ? req_b[31:16] : req_b[15:0];
        mac_c  <= win ? req_c[31:16] : req_c[15:0];
      end
      tag_v  <= LAT'({tag_v, mac_valid});
      tag_id <= LAT'({tag_id, mac_id});
      err    <= err || (mac_res_valid != tag_v[LAT-1]);
      for (int i = 0; i < 2; i++) credit[i] <= credit[i] + CW'(gnt[i]) - CW'(rsp_hs[i]);
    end
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    bf16_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .wr_data (wdata),
      .rd_en   (rsp_ready[g]),
      .rd_data (rsp_data[16*g +: 16]),
      .valid   (rsp_valid[g])
    );
  end
endmodule

// File: tb/tb_bf16_mac_arb.sv
// tb_bf16_mac_arb: scoreboard bench with a fixed-latency MAC responder model
module tb_bf16_mac_arb;
  localparam int LAT = 3, DEPTH = 4;
  logic clk = 0, rst = 0, inject = 0;
  logic [1:0] req_valid = 0, rsp_ready = 0, req_ready, rsp_valid;
  logic [31:0] req_a = 0, req_b = 0, req_c = 0, rsp_data;
  logic mac_valid, mac_res_valid, busy, err;
  logic [15:0] mac_a, mac_b, mac_c, mac_res, kv;
  logic [LAT-1:0] mv;
  logic [15:0] mr [LAT];
  logic [15:0] sb0[$], sb1[$];
  int n_chk = 0, n_fail = 0, acc, base;
  int n_rsp[2] = '{0, 0};
  logic [1:0] pat [5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
  logic [1:0] gexp [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01};

  bf16_mac_arb #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_res_valid(mac_res_valid), .mac_res(mac_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // stand-in MAC: reversible scramble that equals a*b+c whenever a=1.0 and c=0
  function automatic logic [15:0] mac_fn(logic [15:0] a, logic [15:0] b, logic [15:0] c);
    return (a - 16'h3F80) ^ b ^ c;
  endfunction

  function automatic logic [15:0] exp_res(logic [15:0] x);
`ifdef BF16_FTZ_EN
    return (x[14:7] == 8'h00) ? {x[15:7], 7'h00} : x;
`else
    return x;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst)
    if (rst) mv <= '0;
    else mv <= LAT'({mv, mac_valid});
  always_ff @(posedge clk) begin
    mr[0] <= mac_fn(mac_a, mac_b, mac_c);
    for (int k = 1; k < LAT; k++) mr[k] <= mr[k-1];
  end
  assign mac_res_valid = mv[LAT-1] | inject;
  assign mac_res = mr[LAT-1];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 0;
    rsp_ready = 2'b11;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (rsp_valid == 0 && !busy) break;
      cyc(1);
    end
    check("drain_idle", {rsp_valid, busy}, 0);
    check("sb_empty", sb0.size() + sb1.size(), 0);
  endtask

  task automatic wait_rsp0();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rsp_valid[0]) return;
      cyc(1);
    end
    check("rsp0_timeout", 0, 1);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (req_valid[0] && req_ready[0]) sb0.push_back(exp_res(mac_fn(req_a[15:0], req_b[15:0], req_c[15:0])));
      if (req_valid[1] && req_ready[1]) sb1.push_back(exp_res(mac_fn(req_a[31:16], req_b[31:16], req_c[31:16])));
      if (rsp_valid[0] && rsp_ready[0]) begin
        n_rsp[0]++;
        if (sb0.size() == 0) check("rsp0_extra", 1, 0);
        else check("rsp0_data", rsp_data[15:0], sb0.pop_front());
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        n_rsp[1]++;
        if (sb1.size() == 0) check("rsp1_extra", 1, 0);
        else check("rsp1_data", rsp_data[31:16], sb1.pop_front());
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1;
    req_valid = 2'b11;
    #11;
    check("rst_ready", req_ready, 0);
    check("rst_outs", {mac_valid, rsp_valid, busy, err}, 0);
    check("rst_data", rsp_data, 0);
    check("rst_mac", {mac_a, mac_b}, 0);
    req_valid = 0;
    @(posedge clk); #1 rst = 0;
    // fairness: both requesters continuously valid
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      kv = 16'(k);
      req_valid = 2'b11;
      req_a = {16'h3F80, 16'h3F80};
      req_b = {16'h4100 + kv, 16'h4000 + kv};
      req_c = {kv, 16'h0010 + kv};
      @(negedge clk);
      check("fair_gnt", req_ready, (k % 2) ? 2'b10 : 2'b01);
      cyc(1);
    end
    drain();
    check("fair_cnt0", n_rsp[0], 3);
    check("fair_cnt1", n_rsp[1], 3);
    // single op latency
    cyc(1);
    rsp_ready = 0;
    req_valid = 2'b01;
    req_a = 32'h0000_3F80; req_b = 32'h0000_4000; req_c = 0;
    @(negedge clk);
    check("single_ready", req_ready, 2'b01);
    cyc(1);
    req_valid = 0;
    @(negedge clk);
    check("single_mac_valid", mac_valid, 1);
    check("single_mac_ops", {mac_a, mac_b}, 32'h3F80_4000);
    check("single_mac_c", mac_c, 0);
    check("single_busy", busy, 1);
    cyc(1);
    @(negedge clk);
    check("single_mac_drop", mac_valid, 0);
    cyc(LAT - 1);
    @(negedge clk);
    check("single_early", rsp_valid, 0);
    cyc(1);
    @(negedge clk);
    check("single_rsp_valid", rsp_valid, 2'b01);
    check("single_rsp_data", rsp_data, 32'h0000_4000);
    cyc(1);
    rsp_ready = 2'b01;
    @(negedge clk);
    cyc(1);
    rsp_ready = 0;
    @(negedge clk);
    check("single_idle", {rsp_valid, busy}, 0);
    // backpressure on requester 0
    cyc(1);
    acc = 0;
    req_valid = 2'b01;
    req_a = 32'h0000_3F80; req_c = 0;
    for (int k = 0; k < 10; k++) begin
      req_b = 32'h0000_4200 + 32'(k);
      @(negedge clk);
      acc += int'(req_ready[0]);
      cyc(1);
    end
    check("bp_accepts", acc, DEPTH);
    @(negedge clk);
    check("bp_full", req_ready[0], 0);
    check("bp_rsp_valid", rsp_valid[0], 1);
    cyc(1);
    rsp_ready = 2'b01;
    acc = 0;
    @(negedge clk);
    acc += int'(req_ready[0]);
    cyc(1);
    rsp_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc += int'(req_ready[0]);
      cyc(1);
    end
    check("bp_one_more", acc, 1);
    drain();
    // subnormal flush and NaN passthrough
    cyc(1);
    rsp_ready = 0;
    req_valid = 2'b01;
    req_a = 32'h0000_3F80; req_b = 32'h0000_8045; req_c = 0;
    cyc(1);
    req_b = 32'h0000_7FC1;
    cyc(1);
    req_valid = 0;
    wait_rsp0();
`ifdef BF16_FTZ_EN
    check("ftz_head", rsp_data[15:0], 16'h8000);
`else
    check("ftz_head", rsp_data[15:0], 16'h8045);
`endif
    cyc(1);
    rsp_ready = 2'b01;
    @(negedge clk);
    cyc(1);
    rsp_ready = 0;
    wait_rsp0();
    check("nan_head", rsp_data[15:0], 16'h7FC1);
    drain();
    // reset with ops queued and in flight; pointer left at requester 1
    cyc(1);
    rsp_ready = 0;
    for (int k = 0; k < 5; k++) begin
      kv = 16'(k);
      req_valid = pat[k];
      req_a = {16'h3F80, 16'h3F80};
      req_b = {16'h4500 + kv, 16'h4400 + kv};
      req_c = 0;
      @(negedge clk);
      check("pre_rst_gnt", req_ready, gexp[k]);
      cyc(1);
    end
    req_valid = 0;
    cyc(1);
    check("pre_rst_queued", rsp_valid, 2'b11);
    req_valid = 2'b11;
    rst = 1;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_outs", {mac_valid, rsp_valid, busy, err}, 0);
    check("mid_rst_data", rsp_data, 0);
    check("mid_rst_mac", {mac_a, mac_b}, 0);
    check("mid_rst_mac_c", mac_c, 0);
    sb0.delete();
    sb1.delete();
    base = n_rsp[0];
    req_a = {16'h3F80, 16'h3F80}; req_b = {16'h3F80, 16'h3F80}; req_c = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_ptr", req_ready, 2'b01);
    cyc(1);
    drain();
    check("post_rst_rsp", n_rsp[0] - base, 1);
    // protocol error injection
    check("err_clean", err, 0);
    cyc(1);
    inject = 1;
    @(negedge clk);
    check("err_pre", err, 0);
    cyc(1);
    inject = 0;
    @(negedge clk);
    check("err_set", err, 1);
    cyc(3);
    @(negedge clk);
    check("err_sticky", err, 1);
    rst = 1;
    #1;
    check("err_rst", err, 0);
    cyc(1);
    rst = 0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bf16_mac_arb.md
BF16_MAC_ARB -- requirements
Module: bf16_mac_arb

Interface
REQ-001 SHALL have parameter LAT, default 3, meaning the fixed cycle latency of the shared external bf16 MAC from mac_valid to its result; legal range 1..8.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the response FIFO depth per requester and the maximum credits per requester; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 2 bits: per-requester operation valid, bit i = requester i.
REQ-006 SHALL have port req_ready, output, 2 bits: per-requester accept.
REQ-007 SHALL have ports req_a, req_b and req_c, each input, 32 bits: two packed bf16 operands, [16i+15:16i] belonging to requester i; the MAC computes a*b+c.
REQ-008 SHALL have port mac_valid, output, 1 bit: issue strobe to the shared MAC.
REQ-009 SHALL have ports mac_a, mac_b and mac_c, each output, 16 bits: the issued operands.
REQ-010 SHALL have port mac_res_valid, input, 1 bit: MAC result strobe.
REQ-011 SHALL have port mac_res, input, 16 bits: MAC result, bf16.
REQ-012 SHALL have port rsp_valid, output, 2 bits: per-requester response valid.
REQ-013 SHALL have port rsp_ready, input, 2 bits: per-requester response accept.
REQ-014 SHALL have port rsp_data, output, 32 bits: packed per-requester bf16 results.
REQ-015 SHALL have port busy, output, 1 bit: high while any credit is nonzero.
REQ-016 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-017 SHALL treat requester i as eligible when req_valid[i]=1 and credit[i]<DEPTH, where credit = FIFO occupancy + in-flight operations.
REQ-018 SHALL grant at most one requester per cycle using a round-robin pointer:
- Both requesters eligible: the requester the pointer selects wins.
- One requester eligible: that requester wins.
- After any grant, the pointer moves to the requester that did not win.
- With no grant, the pointer holds.
REQ-019 SHALL drive req_ready[i]=1 exactly on the cycle requester i is granted; the handshake is req_valid[i] & req_ready[i].
REQ-020 SHALL register the granted operands, driving mac_valid=1 with mac_a/b/c on the cycle after the handshake; otherwise mac_valid=0 and the operands hold.
REQ-021 SHALL track the owner of each issued operation in a LAT-stage tag pipeline (valid bit + requester id) advancing every cycle.
REQ-022 SHALL, when the tag-pipe output is valid, write mac_res (after the REQ-030 processing) into the owner's FIFO on that cycle.
REQ-023 SHALL assert rsp_valid[i] whenever FIFO i is non-empty, with rsp_data[i] equal to the FIFO head; results are returned in order per requester.
REQ-024 SHALL have a minimum latency from request handshake to rsp_valid of LAT+2 cycles.
REQ-025 SHALL update credit[i] as follows:
- +1 on a handshake of requester i.
- −1 on rsp_valid[i] & rsp_ready[i].
- Both on the same cycle: unchanged.
REQ-026 SHALL never overflow a FIFO; REQ-017 guarantees this. When credit=DEPTH, req_ready[i] SHALL be 0.
REQ-027 SHALL set err=1 on any cycle where mac_res_valid differs from the tag-pipe output valid; err is cleared only by reset.
REQ-028 SHALL drive busy combinationally from the credit counters.

Reset
REQ-029 SHALL, while rst=1, clear the following, with no cycle needed after deassertion:
- Outputs: req_ready, mac_valid, mac_a/b/c, rsp_valid, rsp_data, busy and err all 0.
- State: pointer = requester 0; credits 0; FIFOs empty; tag pipe invalid.
- In-flight operations are discarded.

Configuration
REQ-030 SHALL, with macro BF16_FTZ_EN defined, flush subnormal results before the FIFO write:
- Exponent field [14:7]==0 forces mantissa [6:0] to 0, keeping sign and exponent (signed zero).
- Exponent 0xFF (Inf/NaN) and normal values pass unchanged.
- Without BF16_FTZ_EN, mac_res is written unmodified.

Structure
REQ-031 SHALL place in shared package bf16_pkg:
- Typedef bf16_t, a packed struct of sign, exp[7:0] and man[6:0].
- Constants BF16_EXP_W=8 and BF16_MAN_W=7.
- Function bf16_ftz.
REQ-032 SHALL implement the response buffer as sub-module bf16_rsp_fifo (parameter DEPTH, 16-bit data, registered), instantiated twice.

Verification
REQ-033 SHALL verify single op: req_valid=01, a=0x3F80, b=0x4000, c=0x0000, MAC model returns 0x4000 -> mac_valid at cycle 1, rsp_valid[0] at cycle LAT+2, rsp_data[15:0]=0x4000, busy falls after rsp handshake.
REQ-034 SHALL verify fairness: both requesters valid for 6 cycles -> grant order 0,1,0,1,0,1 and each rsp stream returns 3 results in order.
REQ-035 SHALL verify backpressure: rsp_ready=00, requester 0 streaming -> exactly DEPTH=4 accepts, then req_ready[0]=0; one rsp handshake -> exactly one further accept.
REQ-036 SHALL verify FTZ: mac_res=0x8045 -> rsp_data=0x8000 with BF16_FTZ_EN and 0x8045 without; 0x7FC1 unchanged in both builds.
REQ-037 SHALL verify reset: rst pulse with 3 ops in flight and 2 queued -> all outputs 0 immediately, pointer=0; the first op after reset is accepted normally.
REQ-038 SHALL verify err: inject mac_res_valid=1 with the tag pipe empty -> err=1 next cycle, staying 1 until rst.
